// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN:1 mux, radix-2 tree, one register stage per level.
// Optional MUX_SEL_RANGE_CHECK_EN: flag out-of-range sel on out_err.
// Ports: clk, rst_n (async low); in_data/in_sel/in_valid/in_ready;
//        out_data/out_valid/out_ready/out_err.
module mux_tree_pipe #(
  parameter  int NUM_IN = 64,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_err
);

  localparam int PAD  = 1 << SEL_W;
  localparam int STOT = (SEL_W > 1) ? (SEL_W * (SEL_W - 1)) / 2 : 1;

  logic                     en;
  logic [PAD*DATA_W-1:0]    pad_data;
  // All levels' candidates packed: level l starts at PAD - (PAD >> l).
  logic [(PAD-1)*DATA_W-1:0] dq;
  // Remaining sel bits per level, triangular packing.
  logic [STOT-1:0]          sq;
  logic [SEL_W-1:0]         vq;

  assign en        = out_ready || !out_valid;
  assign in_ready  = en;
  assign out_valid = vq[SEL_W-1];
  assign out_data  = dq[(PAD-2)*DATA_W +: DATA_W];

  // Missing channels read as zero.
  always_comb begin
    pad_data = '0;
    pad_data[NUM_IN*DATA_W-1:0] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vq <= '0;
    end else if (en) begin
      vq <= (vq << 1) | SEL_W'(in_valid);
    end
  end

`ifdef MUX_SEL_RANGE_CHECK_EN
  logic [SEL_W-1:0] eq;
  logic             err_in;

  assign err_in  = in_valid &&
                   ({1'b0, in_sel} >= (SEL_W+1)'(NUM_IN));
  assign out_err = eq[SEL_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq <= '0;
    end else if (en) begin
      eq <= (eq << 1) | SEL_W'(err_in);
    end
  end
`else
  assign out_err = 1'b0;
`endif

  if (SEL_W == 1) begin : g_nosel
    logic unused_sq;
    assign sq        = '0;
    assign unused_sq = ^sq;
  end

  for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
    localparam int NC = PAD >> (l + 1);
    localparam int DO = PAD - (PAD >> l);
    localparam int SO = l * (SEL_W - 1) - (l * (l - 1)) / 2;

    logic [2*NC*DATA_W-1:0] d_in;
    logic [NC*DATA_W-1:0]   d_nxt;
    logic                   s_bit;

    if (l == 0) begin : g_first
      assign d_in  = pad_data;
      assign s_bit = in_sel[0];
    end else begin : g_next
      localparam int DP = PAD - (PAD >> (l - 1));
      localparam int SP = (l - 1) * (SEL_W - 1)
                        - ((l - 1) * (l - 2)) / 2;
      assign d_in  = dq[DP*DATA_W +: 2*NC*DATA_W];
      assign s_bit = sq[SP];
    end

    always_comb begin
      d_nxt = '0;
      for (int c = 0; c < NC; c++) begin
        d_nxt[c*DATA_W +: DATA_W] = s_bit
          ? d_in[(2*c+1)*DATA_W +: DATA_W]
          : d_in[(2*c)*DATA_W +: DATA_W];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dq[DO*DATA_W +: NC*DATA_W] <= '0;
      end else if (en) begin
        dq[DO*DATA_W +: NC*DATA_W] <= d_nxt;
      end
    end

    // Sel bits still needed by later levels ride along.
    if (l < SEL_W - 1) begin : g_sel
      logic [SEL_W-2-l:0] s_nxt;

      if (l == 0) begin : g_s0
        assign s_nxt = in_sel[SEL_W-1:1];
      end else begin : g_sn
        localparam int SP = (l - 1) * (SEL_W - 1)
                          - ((l - 1) * (l - 2)) / 2;
        assign s_nxt = sq[SP+1 +: SEL_W-1-l];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sq[SO +: SEL_W-1-l] <= '0;
        end else if (en) begin
          sq[SO +: SEL_W-1-l] <= s_nxt;
        end
      end
    end
  end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer with valid/ready handshake on input and output.
- Generalises the registered 2:1 mux into the full 64:1 MUX datapath.
- Built as a radix-2 tree with one register stage per tree level; select bits travel alongside the data.
- Sits between the wide channel bus and downstream consumers that may stall.

Parameters:
- NUM_IN, 64, number of input channels; legal range 2..256; need not be a power of two.
- DATA_W, 8, width of each channel in bits; legal range 1..64.
- SEL_W (localparam), $clog2(NUM_IN), select width; also equals LEVELS, the pipeline depth.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  NUM_IN*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
- in_sel  input  SEL_W  channel index, sampled with in_data.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- out_data  output  DATA_W  selected channel.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_err  output  1  selected index was out of range (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - out_data=0, out_valid=0, out_err=0.
  - All stage valid bits cleared; stage data and sel registers cleared to 0.
  - in_ready is 1 immediately after reset because the pipeline is empty.
- Tree structure:
  - Pad the input to 2^SEL_W channels; padded channels read 0.
  - Level L (0..SEL_W-1) halves the candidate set using sel bit L (LSB first). Stage L holds 2^(SEL_W-1-L) candidates of DATA_W bits, the remaining sel bits [SEL_W-1:L+1], a valid bit and an err bit.
  - Final stage output drives out_data, out_valid and out_err directly from registers.
- Latency: exactly SEL_W cycles from an accepted input beat to out_valid (6 for NUM_IN=64, 1 for NUM_IN=2).
- Throughput: one beat per cycle when out_ready is held high.
- Stall (global enable):
  - en = out_ready || !out_valid.
  - All stages advance only when en=1; in_ready = en (combinational).
  - Input is accepted when in_valid && in_ready.
  - When en=0 every stage holds data and valid; nothing is lost or duplicated.
- Bubbles: when in_valid=0 and en=1, stage 0 loads valid=0. Data registers may load or hold; their contents are don't-care while valid=0.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_err are held stable.
- Ordering: beats leave in acceptance order; no reordering.
- Simultaneous events: a beat may be accepted in the same cycle the final beat is consumed.
- Reset mid-operation: all in-flight beats are discarded; no partial output appears after release.

Optional Feature:
- Macro MUX_SEL_RANGE_CHECK_EN.
- Defined:
  - On accept, in_sel >= NUM_IN sets the beat's err bit.
  - That beat emerges with out_err=1 and out_data=0, at the same latency as a normal beat.
- Undefined:
  - out_err is tied to 0 and no err bits are stored.
  - An out-of-range sel returns 0 via the zero padding.
  - For power-of-two NUM_IN both variants are functionally identical apart from out_err.

Test Plan:
- NUM_IN=64, DATA_W=8, channel k = k+8'h10, out_ready=1; send sel=0,1,63,32 back-to-back -> out_data 8'h10,8'h11,8'h4F,8'h30 in order, first out_valid 6 cycles after first accept, then one beat per cycle.
- Stall: stream sel=5..12 continuously, hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 throughout, out_data held stable, no beat lost or duplicated, all 8 values emerge in order.
- Bubbles: alternate in_valid 1/0 with sel=3,7,9 -> out_valid pattern 1,0,1,0,1 delayed 6 cycles, data 8'h13,8'h17,8'h19.
- NUM_IN=5, DATA_W=16, macro defined: sel=4 -> data of channel 4, out_err=0; sel=6 -> out_data=0, out_err=1, 3-cycle latency. Same test with macro undefined -> out_data=0, out_err=0.
- Reset mid-stream: assert rst_n low for 1 cycle while 3 beats are in flight -> out_valid=0 and out_data=0 immediately, no stale beats after release, next beat has full latency.
- NUM_IN=2, DATA_W=8: sel toggling every cycle with out_ready=1 -> 1-cycle latency, correct alternating data, matching the original registered 2:1 mux timing.
